// File: rtl/msrv32_pc_seq.sv
// msrv32_pc_seq: registered program-counter / fetch-address sequencer.
// It selects the next fetch address, tracks AHB wait states, holds one
// pending redirect while the bus is stalled and flags misaligned targets.
// Optional feature macro: MSRV32_RVC_EN. When it is defined, targets need
// only 16-bit alignment and the branch_size_in port picks a 2- or 4-byte
// sequential step.
module msrv32_pc_seq #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [1:0]      pc_src_in,
  input  logic [XLEN-1:0] epc_in,
  input  logic [XLEN-1:0] trap_address_in,
  input  logic            branch_taken_in,
  input  logic [XLEN-1:0] i_addr_in,
  input  logic            ahb_ready_in,
`ifdef MSRV32_RVC_EN
  input  logic            branch_size_in,
`endif
  output logic [XLEN-1:0] pc_mux_out,
  output logic [XLEN-1:0] i_addr_out,
  output logic            i_valid_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus_4_out,
  output logic            misaligned_instr_logic_out,
  output logic            redirect_pending_out
);

  localparam logic [1:0] SRC_BOOT = 2'b00;
  localparam logic [1:0] SRC_EPC  = 2'b01;
  localparam logic [1:0] SRC_TRAP = 2'b10;
  localparam logic [1:0] SRC_OP   = 2'b11;

  // Branch targets always have bit 0 cleared.
  localparam logic [XLEN-1:0] LSB_MASK = {{(XLEN-1){1'b1}}, 1'b0};
  localparam logic [XLEN-1:0] STEP_4   = XLEN'(4);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] i_addr_q, i_addr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic            mis_q, mis_d;
  logic            pend_q, pend_d;
  logic [XLEN-1:0] hold_q, hold_d;
  logic            hold_trap_q, hold_trap_d;

  logic [XLEN-1:0] step;
  logic [XLEN-1:0] branch_target;
  logic            redirect;
  logic            is_trap;
  logic            misaligned;

  // Sequential step size: compressed instructions advance by 2 when enabled.
`ifdef MSRV32_RVC_EN
  always_comb begin
    step = branch_size_in ? XLEN'(2) : STEP_4;
  end
`else
  always_comb begin
    step = STEP_4;
  end
`endif

  assign branch_target = i_addr_in & LSB_MASK;
  assign redirect      = (pc_src_in != SRC_OP) | branch_taken_in;
  assign is_trap       = (pc_src_in == SRC_TRAP);

  // Only a taken branch in operating mode can produce a misaligned target.
`ifdef MSRV32_RVC_EN
  assign misaligned = 1'b0;
`else
  assign misaligned = (pc_src_in == SRC_OP) & branch_taken_in & i_addr_in[1];
`endif

  // Combinational next-address select; additions wrap naturally at XLEN bits.
  always_comb begin
    pc_mux_out = i_addr_q + step;
    unique case (pc_src_in)
      SRC_BOOT: pc_mux_out = RESET_VECTOR;
      SRC_EPC:  pc_mux_out = epc_in;
      SRC_TRAP: pc_mux_out = trap_address_in;
      SRC_OP:   pc_mux_out = branch_taken_in ? branch_target : (i_addr_q + step);
      default:  pc_mux_out = RESET_VECTOR;
    endcase
  end

  // Next-state and register-update logic for the fetch sequencer.
  always_comb begin
    state_d     = state_q;
    i_addr_d    = i_addr_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    mis_d       = 1'b0;
    pend_d      = pend_q;
    hold_d      = hold_q;
    hold_trap_d = hold_trap_q;

    unique case (state_q)
      ST_RESET: begin
        state_d = ST_RUN;
        valid_d = 1'b1;
      end

      ST_RUN: begin
        if (misaligned) begin
          // The flag is a one-cycle pulse; the core answers with a trap.
          mis_d = ~mis_q;
        end else if (ahb_ready_in) begin
          pc_d     = i_addr_q;
          i_addr_d = pc_mux_out;
        end else if (redirect) begin
          hold_d      = pc_mux_out;
          hold_trap_d = is_trap;
          pend_d      = 1'b1;
          state_d     = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (ahb_ready_in) begin
          // A trap arriving on the release cycle beats whatever was held.
          pc_d        = i_addr_q;
          i_addr_d    = is_trap ? trap_address_in : hold_q;
          pend_d      = 1'b0;
          hold_trap_d = 1'b0;
          state_d     = ST_RUN;
        end else if (misaligned) begin
          mis_d = ~mis_q;
        end else if (redirect && (!hold_trap_q || is_trap)) begin
          // A held trap can only be replaced by another trap.
          hold_d      = pc_mux_out;
          hold_trap_d = is_trap;
        end
      end

      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  // State registers with synchronous reset; reset also drops any held redirect.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_RESET;
      i_addr_q    <= RESET_VECTOR;
      pc_q        <= RESET_VECTOR;
      valid_q     <= 1'b0;
      mis_q       <= 1'b0;
      pend_q      <= 1'b0;
      hold_q      <= '0;
      hold_trap_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_addr_q    <= i_addr_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      mis_q       <= mis_d;
      pend_q      <= pend_d;
      hold_q      <= hold_d;
      hold_trap_q <= hold_trap_d;
    end
  end

  assign i_addr_out                 = i_addr_q;
  assign pc_out                     = pc_q;
  assign pc_plus_4_out              = pc_q + step;
  assign i_valid_out                = valid_q;
  assign misaligned_instr_logic_out = mis_q;
  assign redirect_pending_out       = pend_q;

endmodule
